// File: rtl/load_store_unit_if.sv
// Data-memory request/response bundle between the load/store unit (master)
// and the data memory (slave).
interface load_store_unit_if;
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWdata;
  logic [3:0]  MemBe;
  logic        MemAck;
  logic [31:0] MemRdata;

  modport master (
    output MemReq, MemWe, MemAddr, MemWdata, MemBe,
    input  MemAck, MemRdata
  );

  modport slave (
    input  MemReq, MemWe, MemAddr, MemWdata, MemBe,
    output MemAck, MemRdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32 load/store unit: one access per Start, byte/half/word lanes, bus timeout.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     Start,
  input  logic [31:0]              InstCode,
  input  logic [31:0]              Addr,
  input  logic [31:0]              StoreData,
  output logic                     Busy,
  output logic                     Done,
  output logic [31:0]              LoadData,
  output logic                     Fault,
  load_store_unit_if.master        mem
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT_CYCLES - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic legal_f3(input logic is_store, input logic [2:0] f3);
    logic ok;
    if (is_store) begin
      ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    end else begin
      ok = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
    end
    return ok;
  endfunction

  function automatic logic [3:0] be_for(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << lo;
      2'b01:   be = 4'b0011 << {lo[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] wdata_for(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] w;
    case (size)
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Lane select follows the byte offset; halfword lanes ignore Addr[0].
  function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(rd >> {lo, 3'b000});
    h = 16'(rd >> {lo[1], 4'b0000});
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      3'b010:  r = rd;
      default: r = rd;
    endcase
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;
  logic [31:0] load_data_q, load_data_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;

  logic        is_load_s;
  logic        is_store_s;
  logic [2:0]  f3_s;
  logic        misalign_s;
  logic        unused_inst_s;

  assign is_load_s     = (InstCode[6:0] == OP_LOAD);
  assign is_store_s    = (InstCode[6:0] == OP_STORE);
  assign f3_s          = InstCode[14:12];
  assign unused_inst_s = ^{InstCode[31:15], InstCode[11:7]};

  // Alignment check for the incoming access.
  always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
    case (f3_s[1:0])
      2'b01:   misalign_s = Addr[0];
      2'b10:   misalign_s = (Addr[1:0] != 2'b00);
      default: misalign_s = 1'b0;
    endcase
`else
    misalign_s = 1'b0;
`endif
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_store_d  = is_store_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    load_data_d = load_data_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    done_d      = 1'b0;
    fault_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Start && (is_load_s || is_store_s)) begin
          is_store_d = is_store_s;
          funct3_d   = f3_s;
          addr_lo_d  = Addr[1:0];
          if (!legal_f3(is_store_s, f3_s) || misalign_s) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            fault_d = 1'b1;
          end else begin
            state_d     = ST_BUS;
            cnt_d       = 8'd0;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store_s;
            mem_addr_d  = {Addr[31:2], 2'b00};
            mem_be_d    = be_for(f3_s[1:0], Addr[1:0]);
            mem_wdata_d = wdata_for(f3_s[1:0], StoreData);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUS: begin
        // An ack in the final cycle wins over the timeout.
        if (mem.MemAck) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (!is_store_q) begin
            load_data_d = extend_load(funct3_q, addr_lo_q, mem.MemRdata);
          end else begin
            load_data_d = load_data_q;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          fault_d   = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'd0;
      addr_lo_q   <= 2'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      load_data_q <= 32'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_be_q    <= 4'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_store_q  <= is_store_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      load_data_q <= load_data_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
    end
  end

  assign Busy         = busy_q;
  assign Done         = done_q;
  assign Fault        = fault_q;
  assign LoadData     = load_data_q;
  assign mem.MemReq   = mem_req_q;
  assign mem.MemWe    = mem_we_q;
  assign mem.MemAddr  = mem_addr_q;
  assign mem.MemWdata = mem_wdata_q;
  assign mem.MemBe    = mem_be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
module tb_load_store_unit;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  logic        clk;
  logic        rst_n;
  logic        Start;
  logic [31:0] InstCode;
  logic [31:0] Addr;
  logic [31:0] StoreData;
  logic        Busy;
  logic        Done;
  logic [31:0] LoadData;
  logic        Fault;
  int          n_cmp;
  int          n_bad;

  load_store_unit_if mem_bus ();

  load_store_unit #(.TIMEOUT_CYCLES(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Start     (Start),
    .InstCode  (InstCode),
    .Addr      (Addr),
    .StoreData (StoreData),
    .Busy      (Busy),
    .Done      (Done),
    .LoadData  (LoadData),
    .Fault     (Fault),
    .mem       (mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called #1 after a rising edge; returns #1 after the edge that samples Start.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d);
    Start     = 1'b1;
    InstCode  = {17'd0, f3, 5'd0, op};
    Addr      = a;
    StoreData = d;
    @(posedge clk); #1;
    Start     = 1'b0;
  endtask

  task automatic ack(input logic [31:0] rdata);
    mem_bus.MemAck   = 1'b1;
    mem_bus.MemRdata = rdata;
    @(posedge clk); #1;
    mem_bus.MemAck   = 1'b0;
    mem_bus.MemRdata = 32'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({Busy, Done, Fault, mem_bus.MemReq, mem_bus.MemWe} !== 5'b0) begin n_bad++; $display("FAIL reset_ctrl: got %b want 00000", {Busy, Done, Fault, mem_bus.MemReq, mem_bus.MemWe}); end
    n_cmp++; if ({mem_bus.MemAddr, mem_bus.MemWdata, mem_bus.MemBe, LoadData} !== 100'd0) begin n_bad++; $display("FAIL reset_data: got %h want 0", {mem_bus.MemAddr, mem_bus.MemWdata, mem_bus.MemBe, LoadData}); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store_sb();
    issue(OP_STORE, 3'b000, 32'h0000_1003, 32'h0000_00A5);
    n_cmp++; if ({Busy, mem_bus.MemReq, mem_bus.MemWe} !== 3'b111) begin n_bad++; $display("FAIL sb_req: got %b want 111", {Busy, mem_bus.MemReq, mem_bus.MemWe}); end
    n_cmp++; if (mem_bus.MemAddr !== 32'h0000_1000) begin n_bad++; $display("FAIL sb_addr: got %h want 00001000", mem_bus.MemAddr); end
    n_cmp++; if (mem_bus.MemBe !== 4'b1000) begin n_bad++; $display("FAIL sb_be: got %b want 1000", mem_bus.MemBe); end
    n_cmp++; if (mem_bus.MemWdata !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL sb_wdata: got %h want a5a5a5a5", mem_bus.MemWdata); end
    ack(32'd0);
    n_cmp++; if ({Done, Fault, mem_bus.MemReq, LoadData} !== {3'b100, 32'd0}) begin n_bad++; $display("FAIL sb_done: got %b/%h want 100/0", {Done, Fault, mem_bus.MemReq}, LoadData); end
    @(posedge clk); #1;
    n_cmp++; if ({Busy, Done, Fault} !== 3'b000) begin n_bad++; $display("FAIL sb_idle: got %b want 000", {Busy, Done, Fault}); end
  endtask

  task automatic test_store_sh_sw();
    issue(OP_STORE, 3'b001, 32'h0000_2002, 32'h1234_BEEF);
    n_cmp++; if ({mem_bus.MemBe, mem_bus.MemWdata} !== {4'b1100, 32'hBEEF_BEEF}) begin n_bad++; $display("FAIL sh_lane: got %b/%h want 1100/beefbeef", mem_bus.MemBe, mem_bus.MemWdata); end
    ack(32'd0);
    @(posedge clk); #1;
    issue(OP_STORE, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF);
    n_cmp++; if ({mem_bus.MemBe, mem_bus.MemWdata, mem_bus.MemAddr} !== {4'b1111, 32'hDEAD_BEEF, 32'h0000_0010}) begin n_bad++; $display("FAIL sw_lane: got %b/%h/%h want 1111/deadbeef/00000010", mem_bus.MemBe, mem_bus.MemWdata, mem_bus.MemAddr); end
    ack(32'd0);
    @(posedge clk); #1;
  endtask

  task automatic test_load_byte();
    issue(OP_LOAD, 3'b000, 32'h0000_2001, 32'd0);
    n_cmp++; if ({Done, mem_bus.MemReq, mem_bus.MemWe, mem_bus.MemBe} !== 7'b0100010) begin n_bad++; $display("FAIL lb_bus: got %b want 0100010", {Done, mem_bus.MemReq, mem_bus.MemWe, mem_bus.MemBe}); end
    n_cmp++; if (mem_bus.MemAddr !== 32'h0000_2000) begin n_bad++; $display("FAIL lb_addr: got %h want 00002000", mem_bus.MemAddr); end
    ack(32'h1234_F0AA);
    n_cmp++; if ({Done, Fault, LoadData} !== {2'b10, 32'hFFFF_FFF0}) begin n_bad++; $display("FAIL lb_data: got %b/%h want 10/fffffff0", {Done, Fault}, LoadData); end
    @(posedge clk); #1;
    issue(OP_LOAD, 3'b100, 32'h0000_2001, 32'd0);
    ack(32'h1234_F0AA);
    n_cmp++; if ({Done, Fault, LoadData} !== {2'b10, 32'h0000_00F0}) begin n_bad++; $display("FAIL lbu_data: got %b/%h want 10/000000f0", {Done, Fault}, LoadData); end
    @(posedge clk); #1;
  endtask

  task automatic test_load_half_word();
    issue(OP_LOAD, 3'b001, 32'h0000_2002, 32'd0);
    ack(32'h8001_1234);
    n_cmp++; if (LoadData !== 32'hFFFF_8001) begin n_bad++; $display("FAIL lh_data: got %h want ffff8001", LoadData); end
    @(posedge clk); #1;
    issue(OP_LOAD, 3'b101, 32'h0000_2000, 32'd0);
    ack(32'h8001_9234);
    n_cmp++; if (LoadData !== 32'h0000_9234) begin n_bad++; $display("FAIL lhu_data: got %h want 00009234", LoadData); end
    @(posedge clk); #1;
    issue(OP_LOAD, 3'b010, 32'h0000_0040, 32'd0);
    ack(32'hCAFE_F00D);
    n_cmp++; if (LoadData !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL lw_data: got %h want cafef00d", LoadData); end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    int cycles;
    issue(OP_LOAD, 3'b010, 32'h0000_0080, 32'd0);
    cycles = 0;
    while (mem_bus.MemReq === 1'b1 && cycles < 40) begin
      n_cmp++; if (Fault !== 1'b0) begin n_bad++; $display("FAIL to_fault_early: got %b want 0", Fault); end
      cycles++;
      @(posedge clk); #1;
    end
    n_cmp++; if (cycles != 15) begin n_bad++; $display("FAIL to_cycles: got %0d want 15", cycles); end
    n_cmp++; if ({Done, Fault, LoadData} !== {2'b11, 32'hCAFE_F00D}) begin n_bad++; $display("FAIL to_done: got %b/%h want 11/cafef00d", {Done, Fault}, LoadData); end
    @(posedge clk); #1;
    n_cmp++; if ({Busy, Done, Fault} !== 3'b000) begin n_bad++; $display("FAIL to_idle: got %b want 000", {Busy, Done, Fault}); end
    issue(OP_LOAD, 3'b010, 32'h0000_0084, 32'd0);
    repeat (14) begin @(posedge clk); #1; end
    ack(32'h1357_9BDF);
    n_cmp++; if ({Done, Fault, LoadData} !== {2'b10, 32'h1357_9BDF}) begin n_bad++; $display("FAIL to_ack_wins: got %b/%h want 10/13579bdf", {Done, Fault}, LoadData); end
    @(posedge clk); #1;
  endtask

  task automatic test_misalign_illegal();
    issue(OP_LOAD, 3'b001, 32'h0000_3001, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
    n_cmp++; if ({Done, Fault, mem_bus.MemReq, LoadData} !== {3'b110, 32'h1357_9BDF}) begin n_bad++; $display("FAIL lh_trap: got %b/%h want 110/13579bdf", {Done, Fault, mem_bus.MemReq}, LoadData); end
    @(posedge clk); #1;
`else
    n_cmp++; if ({mem_bus.MemReq, mem_bus.MemAddr, mem_bus.MemBe} !== {1'b1, 32'h0000_3000, 4'b0011}) begin n_bad++; $display("FAIL lh_noalign: got %b/%h/%b want 1/00003000/0011", mem_bus.MemReq, mem_bus.MemAddr, mem_bus.MemBe); end
    ack(32'h0000_7FFF);
    n_cmp++; if ({Fault, LoadData} !== {1'b0, 32'h0000_7FFF}) begin n_bad++; $display("FAIL lh_noalign_data: got %b/%h want 0/00007fff", Fault, LoadData); end
    @(posedge clk); #1;
`endif
    issue(OP_LOAD, 3'b011, 32'h0000_0000, 32'd0);
    n_cmp++; if ({Done, Fault, mem_bus.MemReq} !== 3'b110) begin n_bad++; $display("FAIL ld_illegal: got %b want 110", {Done, Fault, mem_bus.MemReq}); end
    @(posedge clk); #1;
    issue(OP_STORE, 3'b100, 32'h0000_0000, 32'd0);
    n_cmp++; if ({Done, Fault, mem_bus.MemReq} !== 3'b110) begin n_bad++; $display("FAIL st_illegal: got %b want 110", {Done, Fault, mem_bus.MemReq}); end
    @(posedge clk); #1;
    n_cmp++; if ({Busy, Done, Fault} !== 3'b000) begin n_bad++; $display("FAIL illegal_idle: got %b want 000", {Busy, Done, Fault}); end
  endtask

  task automatic test_ignored_start();
    issue(OP_ALU, 3'b000, 32'h0000_0500, 32'd0);
    n_cmp++; if ({Busy, mem_bus.MemReq} !== 2'b00) begin n_bad++; $display("FAIL alu_ignored: got %b want 00", {Busy, mem_bus.MemReq}); end
    issue(OP_STORE, 3'b010, 32'h0000_0100, 32'h1111_1111);
    issue(OP_STORE, 3'b010, 32'h0000_0200, 32'h2222_2222);
    n_cmp++; if ({mem_bus.MemReq, mem_bus.MemAddr, mem_bus.MemWdata} !== {1'b1, 32'h0000_0100, 32'h1111_1111}) begin n_bad++; $display("FAIL busy_ignored: got %b/%h/%h want 1/00000100/11111111", mem_bus.MemReq, mem_bus.MemAddr, mem_bus.MemWdata); end
    ack(32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++; if ({Busy, mem_bus.MemReq} !== 2'b00) begin n_bad++; $display("FAIL busy_no_queue: got %b want 00", {Busy, mem_bus.MemReq}); end
  endtask

  task automatic test_reset_mid_bus();
    issue(OP_LOAD, 3'b010, 32'h0000_0600, 32'd0);
    @(posedge clk); #2;
    n_cmp++; if (mem_bus.MemReq !== 1'b1) begin n_bad++; $display("FAIL rst_pre_req: got %b want 1", mem_bus.MemReq); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({Busy, Done, Fault, mem_bus.MemReq, mem_bus.MemBe, mem_bus.MemAddr, LoadData} !== 72'd0) begin n_bad++; $display("FAIL rst_mid_bus: got %h want 0", {Busy, Done, Fault, mem_bus.MemReq, mem_bus.MemBe, mem_bus.MemAddr, LoadData}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++; if ({Busy, mem_bus.MemReq} !== 2'b00) begin n_bad++; $display("FAIL rst_fresh_start: got %b want 00", {Busy, mem_bus.MemReq}); end
    issue(OP_LOAD, 3'b010, 32'h0000_0700, 32'd0);
    ack(32'h0BAD_CAFE);
    n_cmp++; if ({Done, Fault, LoadData} !== {2'b10, 32'h0BAD_CAFE}) begin n_bad++; $display("FAIL rst_recover: got %b/%h want 10/0badcafe", {Done, Fault}, LoadData); end
  endtask

  initial begin
    n_cmp            = 0;
    n_bad            = 0;
    rst_n            = 1'b0;
    Start            = 1'b0;
    InstCode         = 32'd0;
    Addr             = 32'd0;
    StoreData        = 32'd0;
    mem_bus.MemAck   = 1'b0;
    mem_bus.MemRdata = 32'd0;
    #1;
    test_reset();
    test_store_sb();
    test_store_sh_sw();
    test_load_byte();
    test_load_half_word();
    test_timeout();
    test_misalign_illegal();
    test_ignored_start();
    test_reset_mid_bus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
